pll_lock_sequencer: RTL and testbench

Reset/lock sequencer for the core clock PLL, running in the 74.25 MHz reference domain. It holds the PLL in reset for a fixed interval, then waits for lock with a timeout. Lock must stay stable for a settle window before the block releases the core reset; on lock loss or a reconfiguration request it restarts the sequence. It sits between the top-level reset and the PLL instance, and its outputs gate every downstream clock-domain reset.

---
 rtl/pll_seq_pkg.sv | 28 ++
 rtl/pll_lock_sequencer_sync.sv | 28 ++
 rtl/pll_lock_sequencer.sv | 149 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared types and helpers for the PLL reset/lock sequencer.
//   pll_state_t : sequencer state encoding (2-bit)
//   RETRY_W     : width of the saturating retry counter
//   cnt_width() : width of the shared cycle counter, sized from the largest
//                 interval parameter
package pll_seq_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  localparam int RETRY_W = 4;

  // Every terminal count is (parameter - 1), so clog2 of the largest
  // parameter always holds it. Never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync.sv
// bit_sync
// Multi-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears the whole chain to 0
//   din   : asynchronous input level
//   dout  : synchronized level, STAGES cycles behind din
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
    end
  end

  assign dout = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Reset/lock sequencer for the core clock PLL (74.25 MHz reference domain).
// Holds the PLL in reset, waits for lock with a timeout, requires a stable
// settle window, then releases the core reset. Lock loss or a reconfiguration
// request restarts the sequence.
//   clk_74a      : reference clock (same net as the PLL refclk)
//   reset_n      : asynchronous active-low reset
//   pll_locked   : raw PLL lock, asynchronous to clk_74a
//   reconfig_req : single-cycle restart request, honoured only in RUN
//   pll_rst      : PLL reset, active-high
//   core_reset_n : core reset, active-low, high only in RUN
//   pll_ready    : high only in RUN
//   lock_lost    : one-cycle pulse when lock drops in RUN
//   timeout_err  : sticky lock-timeout flag, cleared on entering RUN
//   retry_count  : saturating count of timeouts plus lock losses
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int SETTLE_CYCLES = 1024,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clk_74a,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               reconfig_req,
  output logic               pll_rst,
  output logic               core_reset_n,
  output logic               pll_ready,
  output logic               lock_lost,
  output logic               timeout_err,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = {RETRY_W{1'b1}};

  logic locked_s;

  pll_state_t         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic               timeout_err_reg, timeout_err_next;
  logic               pll_rst_reg, core_reset_n_reg, pll_ready_reg, lock_lost_reg;
  logic               timeout_hit, loss_hit, run_hold;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk_74a),
    .rst_n(reset_n),
    .din  (pll_locked),
    .dout (locked_s)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + CNT_W'(1);
    timeout_hit = 1'b0;
    loss_hit    = 1'b0;

    case (state_reg)
      RESET_PLL: begin
        if (cnt_reg == RST_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = SETTLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next  = RESET_PLL;
          timeout_hit = 1'b1;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
        end else if (cnt_reg == SETTLE_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Counter is idle here; hold it rather than let it wrap.
        cnt_next = cnt_reg;
        if (!locked_s) begin
          // Lock loss wins over a simultaneous reconfig so it is still counted.
          state_next = RESET_PLL;
          loss_hit   = 1'b1;
        end else if (reconfig_req) begin
          state_next = RESET_PLL;
        end
      end
      default: state_next = RESET_PLL;
    endcase

    if (state_next != state_reg) cnt_next = '0;

    retry_next = retry_reg;
    if ((timeout_hit || loss_hit) && (retry_reg != RETRY_MAX)) begin
      retry_next = retry_reg + RETRY_W'(1);
    end

    timeout_err_next = timeout_err_reg;
    if (timeout_hit) begin
      timeout_err_next = 1'b1;
    end else if ((state_next == RUN) && (state_reg != RUN)) begin
      timeout_err_next = 1'b0;
    end
  end

  // Release is granted only once RUN is held across an edge, so the first
  // RUN cycle re-confirms lock before the core comes out of reset; any exit
  // from RUN drops it on the same edge.
  assign run_hold = (state_reg == RUN) && (state_next == RUN);

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= RESET_PLL;
      cnt_reg          <= '0;
      retry_reg        <= '0;
      timeout_err_reg  <= 1'b0;
      pll_rst_reg      <= 1'b1;
      core_reset_n_reg <= 1'b0;
      pll_ready_reg    <= 1'b0;
      lock_lost_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      retry_reg        <= retry_next;
      timeout_err_reg  <= timeout_err_next;
      pll_rst_reg      <= (state_next == RESET_PLL);
      core_reset_n_reg <= run_hold;
      pll_ready_reg    <= run_hold;
      lock_lost_reg    <= loss_hit;
    end
  end

  assign pll_rst      = pll_rst_reg;
  assign core_reset_n = core_reset_n_reg;
  assign pll_ready    = pll_ready_reg;
  assign lock_lost    = lock_lost_reg;
  assign timeout_err  = timeout_err_reg;
  assign retry_count  = retry_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
`timescale 1ns/1ps
// tb_pll_lock_sequencer
// Directed scenarios followed by randomized lock/reconfig traffic. Every cycle
// the DUT outputs are compared against a phase/age reference model; directed
// scenarios add latency and pulse-count checks against fixed expectations.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int SETTLE_CYCLES = 8;
  localparam int SYNC_STAGES   = 2;

  localparam int PH_RST    = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_RUN    = 3;

  localparam int REL_LAT = SYNC_STAGES + 1 + SETTLE_CYCLES + 1;

  logic       clk_74a      = 1'b0;
  logic       reset_n      = 1'b1;
  logic       pll_locked   = 1'b0;
  logic       reconfig_req = 1'b0;
  logic       pll_rst, core_reset_n, pll_ready, lock_lost, timeout_err;
  logic [3:0] retry_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current phase, edges spent in it, and lock history.
  int m_phase;
  int m_age;
  int m_retries;
  bit m_terr;
  bit m_lost;
  bit m_hist[$];

  pll_lock_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .clk_74a     (clk_74a),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .reconfig_req(reconfig_req),
    .pll_rst     (pll_rst),
    .core_reset_n(core_reset_n),
    .pll_ready   (pll_ready),
    .lock_lost   (lock_lost),
    .timeout_err (timeout_err),
    .retry_count (retry_count)
  );

  always #5 clk_74a = ~clk_74a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] got_outs();
    return {pll_rst, core_reset_n, pll_ready, lock_lost, timeout_err, retry_count};
  endfunction

  function automatic logic [8:0] exp_outs();
    logic       rel;
    logic [3:0] rc;
    rel = (m_phase == PH_RUN) && (m_age > 0);
    rc  = (m_retries > 15) ? 4'd15 : 4'(m_retries);
    return {logic'(m_phase == PH_RST), rel, rel, logic'(m_lost), logic'(m_terr), rc};
  endfunction

  task automatic model_reset();
    m_phase   = PH_RST;
    m_age     = 0;
    m_retries = 0;
    m_terr    = 1'b0;
    m_lost    = 1'b0;
    m_hist.delete();
    repeat (SYNC_STAGES) m_hist.push_back(1'b0);
  endtask

  task automatic enter(input int ph);
    m_phase = ph;
    m_age   = 0;
  endtask

  // One clock edge: lock as seen by the sequencer is the level driven
  // SYNC_STAGES edges earlier.
  task automatic model_step(input bit lk, input bit rq);
    bit seen;
    seen = m_hist.pop_front();
    m_hist.push_back(lk);
    m_lost = 1'b0;
    case (m_phase)
      PH_RST: begin
        if (m_age == RST_CYCLES - 1) enter(PH_WAIT);
        else m_age++;
      end
      PH_WAIT: begin
        if (seen) enter(PH_SETTLE);
        else if (m_age == LOCK_TIMEOUT - 1) begin
          enter(PH_RST);
          m_terr = 1'b1;
          m_retries++;
        end else m_age++;
      end
      PH_SETTLE: begin
        if (!seen) enter(PH_WAIT);
        else if (m_age == SETTLE_CYCLES - 1) begin
          enter(PH_RUN);
          m_terr = 1'b0;
        end else m_age++;
      end
      default: begin
        if (!seen) begin
          enter(PH_RST);
          m_lost = 1'b1;
          m_retries++;
        end else if (rq) enter(PH_RST);
        else m_age++;
      end
    endcase
  endtask

  // Called just after a falling edge: drive, clock, compare on the next fall.
  task automatic cycle(input bit lk, input bit rq, input string tag);
    pll_locked   = lk;
    reconfig_req = rq;
    @(posedge clk_74a);
    model_step(lk, rq);
    @(negedge clk_74a);
    check(tag, got_outs(), exp_outs());
  endtask

  task automatic lock_until_run(input string tag, output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      cycle(1'b1, 1'b0, tag);
      if (core_reset_n === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt, rises, last_rise, last_gap;
    logic prev;

    // Reset state
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check("reset_async", got_outs(), exp_outs());
    check("reset_vals", got_outs(), 9'h100);
    @(negedge clk_74a);
    @(negedge clk_74a);
    reset_n = 1'b1;
    check("reset_hold", got_outs(), 9'h100);

    // Power-up: lock arrives 10 cycles after release
    cnt = int'(pll_rst);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, "pwrup");
      cnt += int'(pll_rst);
    end
    check("pwrup_rst_len", cnt, RST_CYCLES);
    lock_until_run("pwrup", lat);
    check("pwrup_latency", lat, REL_LAT);
    check("pwrup_retry", retry_count, 0);
    $display("scenario power-up   latency=%0d checks=%0d", lat, n_checks);

    // Reconfig alone in RUN: restart without counting
    cycle(1'b1, 1'b1, "reconfig");
    check("reconfig_rst", {pll_rst, core_reset_n}, 2'b10);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, "reconfig");
    check("reconfig_retry", retry_count, 0);
    $display("scenario reconfig   retry=%0d checks=%0d", retry_count, n_checks);

    // One-cycle lock glitch at settle count 5
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, "glitch");
    cycle(1'b0, 1'b0, "glitch");
    lock_until_run("glitch", lat);
    check("glitch_latency", lat, REL_LAT);
    check("glitch_retry", retry_count, 0);
    $display("scenario glitch     latency=%0d checks=%0d", lat, n_checks);

    // Lock loss in RUN
    lat = -1;
    cnt = 0;
    rises = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b0, "lockloss");
      if (core_reset_n === 1'b0 && lat < 0) lat = i;
      cnt   += int'(lock_lost);
      rises += int'(pll_rst);
    end
    check("loss_latency", lat, SYNC_STAGES + 1);
    check("loss_pulses", cnt, 1);
    check("loss_rst_len", rises, RST_CYCLES);
    check("loss_retry", retry_count, 1);
    $display("scenario lock-loss  latency=%0d checks=%0d", lat, n_checks);

    // Reconfig coincident with lock loss, then reconfig during WAIT_LOCK
    lock_until_run("both", lat);
    check("both_relock", lat, REL_LAT);
    cnt = 0;
    rises = 0;
    prev = pll_rst;
    for (int i = 1; i <= 13; i++) begin
      cycle(1'b0, (i == 3) || (i == 10), "both");
      cnt += int'(lock_lost);
      if (pll_rst && !prev) rises++;
      prev = pll_rst;
    end
    check("both_pulses", cnt, 1);
    check("both_restarts", rises, 1);
    check("both_retry", retry_count, 2);
    $display("scenario both       restarts=%0d checks=%0d", rises, n_checks);

    // Lock never arrives: periodic retries until saturation
    rises = 0;
    last_rise = 0;
    last_gap = 0;
    prev = pll_rst;
    for (int i = 1; i <= 16 * (RST_CYCLES + LOCK_TIMEOUT); i++) begin
      cycle(1'b0, 1'b0, "timeout");
      if (pll_rst && !prev) begin
        last_gap  = i - last_rise;
        last_rise = i;
        rises++;
      end
      prev = pll_rst;
    end
    check("timeout_period", last_gap, RST_CYCLES + LOCK_TIMEOUT);
    check("timeout_rises", rises, 16);
    check("timeout_sat", retry_count, 15);
    check("timeout_flag", timeout_err, 1);
    $display("scenario timeout    retries=%0d checks=%0d", retry_count, n_checks);

    // Asynchronous reset while in SETTLE
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, "settle_rst");
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("settle_rst_async", got_outs(), exp_outs());
    check("settle_rst_vals", got_outs(), 9'h100);
    @(negedge clk_74a);
    @(negedge clk_74a);
    reset_n = 1'b1;
    lock_until_run("settle_rst", lat);
    check("settle_rst_relock", lat, RST_CYCLES + 1 + SETTLE_CYCLES + 1);
    $display("scenario reset      latency=%0d checks=%0d", lat, n_checks);

    // Randomized lock segments with sparse reconfig requests
    cnt = 0;
    while (cnt < 3000) begin
      bit lk;
      int len;
      lk = 1'($urandom_range(0, 1));
      if (lk) len = $urandom_range(1, 40);
      else if ($urandom_range(0, 9) == 0) len = $urandom_range(90, 130);
      else len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        cycle(lk, $urandom_range(0, 19) == 0, "random");
        cnt++;
      end
    end
    $display("scenario random     cycles=%0d checks=%0d", cnt, n_checks);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
